picorv32_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single PicoRV32-native memory port of the FreeAHB bridge between the CPU core (port 0) and a debug/loader master (port 1). It sits between the requesters and `picorv32_freeahb_adapter`, holds a grant for a whole native transaction, and inserts the one-cycle `mem_valid` gap the bridge needs to return to idle. An optional watchdog aborts transactions the bus never completes.

---
 rtl/picorv32_arb_pkg.sv | 38 +++
 rtl/picorv32_arb_watchdog.sv | 34 +++
 rtl/picorv32_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_arb_pkg.sv
// rtl/picorv32_arb_pkg.sv - shared types and constants for the PicoRV32 memory arbiter
//
// Purpose: arbiter state encoding, one-hot grant encodings, default abort
// read data and the two-port pick function used by picorv32_mem_arbiter.
// Ports: none (package).
package picorv32_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_GAP   = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  localparam logic [1:0]  GNT_NONE = 2'b00;
  localparam logic [1:0]  GNT_C0   = 2'b01;
  localparam logic [1:0]  GNT_C1   = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // last_c1 = 1 means port 1 was served most recently; on a tie with round
  // robin enabled the other port wins, otherwise port 0 always wins.
  function automatic logic [1:0] arb_pick(input logic v0, input logic v1,
                                          input logic rr_en, input logic last_c1);
    logic [1:0] win;
    if (v0 && v1) begin
      win = (rr_en && !last_c1) ? GNT_C1 : GNT_C0;
    end else if (v0) begin
      win = GNT_C0;
    end else if (v1) begin
      win = GNT_C1;
    end else begin
      win = GNT_NONE;
    end
    return win;
  endfunction

endpackage

// File: rtl/picorv32_arb_watchdog.sv
// rtl/picorv32_arb_watchdog.sv - transaction watchdog counter for the memory arbiter
//
// Purpose: 16-bit cycle counter, held at zero by clear, incremented while
// enable is high; expired flags the last permitted cycle (count == LIMIT-1).
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   clear        force count to zero (has priority over enable)
//   enable       count this cycle
//   expired      count has reached LIMIT-1
module picorv32_arb_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == 16'(LIMIT - 1));

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-port arbiter in front of the PicoRV32 FreeAHB bridge
//
// Purpose: shares one PicoRV32-native memory port between the CPU (c0) and a
// debug/loader master (c1). A grant is held for a whole transaction and a
// one-cycle m_mem_valid gap follows every completion so the bridge can idle.
// Optional feature macro: MEM_ARB_TIMEOUT_EN compiles in the watchdog, the
// ABORT state and timeout_err; without it BUSY waits for m_mem_ready forever.
// Ports:
//   clk, resetn                 clock and asynchronous active-low reset
//   c0_mem_* / c1_mem_*         requester native ports (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//   m_mem_*                     native port towards the bridge
//   grant                       one-hot owner (01 = c0, 10 = c1, 00 = none)
//   timeout_err                 one-cycle pulse when a transaction is aborted
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int          ROUND_ROBIN    = 1,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        c0_mem_valid,
  input  logic        c0_mem_instr,
  input  logic [31:0] c0_mem_addr,
  input  logic [31:0] c0_mem_wdata,
  input  logic [3:0]  c0_mem_wstrb,
  output logic        c0_mem_ready,
  output logic [31:0] c0_mem_rdata,
  input  logic        c1_mem_valid,
  input  logic        c1_mem_instr,
  input  logic [31:0] c1_mem_addr,
  input  logic [31:0] c1_mem_wdata,
  input  logic [3:0]  c1_mem_wstrb,
  output logic        c1_mem_ready,
  output logic [31:0] c1_mem_rdata,
  output logic        m_mem_valid,
  output logic        m_mem_instr,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic        m_mem_ready,
  input  logic [31:0] m_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picorv32_mem_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  arb_state_t state;
  logic [1:0] grant_q;
  logic       m_valid_q;
  logic       last_c1;
  logic [1:0] abort_gnt;
  logic [1:0] pick;

  // During ABORT the aborted requester still shows valid (it only drops it
  // after seeing ready), so its stale request is kept out of arbitration.
  assign pick = arb_pick(c0_mem_valid && !abort_gnt[0],
                         c1_mem_valid && !abort_gnt[1],
                         RR_EN, last_c1);

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_expired;
  logic timeout_q;

  // Holding clear outside BUSY leaves the count at zero on every BUSY entry.
  picorv32_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state != ST_BUSY),
    .enable  ((state == ST_BUSY) && !m_mem_ready),
    .expired (wd_expired)
  );

  assign timeout_err = timeout_q;
`else
  assign abort_gnt   = GNT_NONE;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      grant_q   <= GNT_NONE;
      m_valid_q <= 1'b0;
      last_c1   <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      abort_gnt <= GNT_NONE;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      abort_gnt <= GNT_NONE;
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_BUSY: begin
          if (m_mem_ready) begin
            state     <= ST_GAP;
            grant_q   <= GNT_NONE;
            m_valid_q <= 1'b0;
            last_c1   <= grant_q[1];
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            state     <= ST_ABORT;
            grant_q   <= GNT_NONE;
            m_valid_q <= 1'b0;
            abort_gnt <= grant_q;
            timeout_q <= 1'b1;
          end
`endif
        end
        // IDLE, GAP and ABORT all arbitrate the same way.
        default: begin
          if (pick != GNT_NONE) begin
            state     <= ST_BUSY;
            grant_q   <= pick;
            m_valid_q <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            grant_q   <= GNT_NONE;
            m_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign m_mem_valid = m_valid_q;

  // grant_q is non-zero only in BUSY, so the payload mux reads zero elsewhere.
  always_comb begin
    m_mem_instr = 1'b0;
    m_mem_addr  = 32'd0;
    m_mem_wdata = 32'd0;
    m_mem_wstrb = 4'd0;
    case (grant_q)
      GNT_C0: begin
        m_mem_instr = c0_mem_instr;
        m_mem_addr  = c0_mem_addr;
        m_mem_wdata = c0_mem_wdata;
        m_mem_wstrb = c0_mem_wstrb;
      end
      GNT_C1: begin
        m_mem_instr = c1_mem_instr;
        m_mem_addr  = c1_mem_addr;
        m_mem_wdata = c1_mem_wdata;
        m_mem_wstrb = c1_mem_wstrb;
      end
      default: begin
      end
    endcase
  end

  assign c0_mem_ready = (grant_q[0] && m_mem_ready) || abort_gnt[0];
  assign c1_mem_ready = (grant_q[1] && m_mem_ready) || abort_gnt[1];
  assign c0_mem_rdata = abort_gnt[0] ? ERR_RDATA : (grant_q[0] ? m_mem_rdata : 32'd0);
  assign c1_mem_rdata = abort_gnt[1] ? ERR_RDATA : (grant_q[1] ? m_mem_rdata : 32'd0);

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter
//
// Instance 0 uses round robin, instance 1 fixed priority; both watchdog limits are 8.
module tb_picorv32_mem_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        c_valid [2][2];
  logic        c_instr [2][2];
  logic [31:0] c_addr  [2][2];
  logic [31:0] c_wdata [2][2];
  logic [3:0]  c_wstrb [2][2];
  logic        c_ready [2][2];
  logic [31:0] c_rdata [2][2];
  logic        m_valid [2];
  logic        m_instr [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic        m_ready [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  grant   [2];
  logic        terr    [2];

  int errors = 0;
  int checks = 0;

  picorv32_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut_rr (
    .clk(clk), .resetn(resetn),
    .c0_mem_valid(c_valid[0][0]), .c0_mem_instr(c_instr[0][0]), .c0_mem_addr(c_addr[0][0]),
    .c0_mem_wdata(c_wdata[0][0]), .c0_mem_wstrb(c_wstrb[0][0]), .c0_mem_ready(c_ready[0][0]),
    .c0_mem_rdata(c_rdata[0][0]),
    .c1_mem_valid(c_valid[0][1]), .c1_mem_instr(c_instr[0][1]), .c1_mem_addr(c_addr[0][1]),
    .c1_mem_wdata(c_wdata[0][1]), .c1_mem_wstrb(c_wstrb[0][1]), .c1_mem_ready(c_ready[0][1]),
    .c1_mem_rdata(c_rdata[0][1]),
    .m_mem_valid(m_valid[0]), .m_mem_instr(m_instr[0]), .m_mem_addr(m_addr[0]),
    .m_mem_wdata(m_wdata[0]), .m_mem_wstrb(m_wstrb[0]), .m_mem_ready(m_ready[0]),
    .m_mem_rdata(m_rdata[0]), .grant(grant[0]), .timeout_err(terr[0])
  );

  picorv32_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut_fp (
    .clk(clk), .resetn(resetn),
    .c0_mem_valid(c_valid[1][0]), .c0_mem_instr(c_instr[1][0]), .c0_mem_addr(c_addr[1][0]),
    .c0_mem_wdata(c_wdata[1][0]), .c0_mem_wstrb(c_wstrb[1][0]), .c0_mem_ready(c_ready[1][0]),
    .c0_mem_rdata(c_rdata[1][0]),
    .c1_mem_valid(c_valid[1][1]), .c1_mem_instr(c_instr[1][1]), .c1_mem_addr(c_addr[1][1]),
    .c1_mem_wdata(c_wdata[1][1]), .c1_mem_wstrb(c_wstrb[1][1]), .c1_mem_ready(c_ready[1][1]),
    .c1_mem_rdata(c_rdata[1][1]),
    .m_mem_valid(m_valid[1]), .m_mem_instr(m_instr[1]), .m_mem_addr(m_addr[1]),
    .m_mem_wdata(m_wdata[1]), .m_mem_wstrb(m_wstrb[1]), .m_mem_ready(m_ready[1]),
    .m_mem_rdata(m_rdata[1]), .grant(grant[1]), .timeout_err(terr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: owner = port holding the bus (-1 none), ab = port being
  // told about an abort this cycle, waited = bus cycles spent without ready.
  int owner  [2] = '{-1, -1};
  int last   [2] = '{1, 1};
  int ab     [2] = '{-1, -1};
  int waited [2] = '{0, 0};

  function automatic int pick(input int i, input bit a, input bit b);
    if (a && b) return (i == 0) ? 1 - last[i] : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        owner[i] = -1; last[i] = 1; ab[i] = -1; waited[i] = 0;
      end else if (ab[i] >= 0) begin
        owner[i]  = pick(i, c_valid[i][0] && ab[i] != 0, c_valid[i][1] && ab[i] != 1);
        ab[i]     = -1;
        waited[i] = 0;
      end else if (owner[i] < 0) begin
        owner[i]  = pick(i, c_valid[i][0], c_valid[i][1]);
        waited[i] = 0;
      end else if (m_ready[i]) begin
        last[i]  = owner[i];
        owner[i] = -1;
      end else begin
        waited[i]++;
        if (TO_EN && waited[i] == TO) begin
          ab[i]    = owner[i];
          owner[i] = -1;
        end
      end
    end
  end

  initial forever begin
    int o, oi;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o  = owner[i];
      oi = (o < 0) ? 0 : o;
      check($sformatf("i%0d m_valid", i), m_valid[i], (o >= 0));
      check($sformatf("i%0d grant", i), grant[i], (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
      check($sformatf("i%0d m_addr", i), m_addr[i], (o >= 0) ? c_addr[i][oi] : 32'd0);
      check($sformatf("i%0d m_wdata", i), m_wdata[i], (o >= 0) ? c_wdata[i][oi] : 32'd0);
      check($sformatf("i%0d m_wstrb", i), m_wstrb[i], (o >= 0) ? c_wstrb[i][oi] : 4'd0);
      check($sformatf("i%0d m_instr", i), m_instr[i], (o >= 0) ? c_instr[i][oi] : 1'b0);
      check($sformatf("i%0d timeout_err", i), terr[i], (ab[i] >= 0));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("i%0d c%0d ready", i, p), c_ready[i][p],
              ((o == p) && m_ready[i]) || (ab[i] == p));
        check($sformatf("i%0d c%0d rdata", i, p), c_rdata[i][p],
              (ab[i] == p) ? ERR : (o == p) ? m_rdata[i] : 32'd0);
      end
    end
  end

  task automatic new_payload(input int i, input int p);
    c_instr[i][p] = $urandom_range(1);
    c_addr[i][p]  = $urandom;
    c_wdata[i][p] = $urandom;
    c_wstrb[i][p] = $urandom_range(15);
  endtask

  logic [1:0] rr_exp [4];
  logic       seen [2][2];

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b0;
      m_rdata[i] = 32'd0;
      for (int p = 0; p < 2; p++) begin
        c_valid[i][p] = 1'b0; c_instr[i][p] = 1'b0; c_addr[i][p] = 32'd0;
        c_wdata[i][p] = 32'd0; c_wstrb[i][p] = 4'd0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset grant", grant[0], 2'b00);
    check("reset m_valid", m_valid[0], 1'b0);
    check("reset c0 ready", c_ready[0][0], 1'b0);
    resetn = 1'b1;

    // single read: bridge ready on the third bus cycle
    c_valid[0][0] = 1'b1; c_addr[0][0] = 32'h100; c_instr[0][0] = 1'b0;
    tick();
    check("read grant", grant[0], 2'b01);
    check("read m_valid", m_valid[0], 1'b1);
    check("read m_addr", m_addr[0], 32'h100);
    tick();
    tick();
    m_ready[0] = 1'b1; m_rdata[0] = 32'h1122_3344;
    #1;
    check("read c0 ready", c_ready[0][0], 1'b1);
    check("read c0 rdata", c_rdata[0][0], 32'h1122_3344);
    check("read grant at ready", grant[0], 2'b01);
    tick();
    m_ready[0] = 1'b0; c_valid[0][0] = 1'b0;
    check("read gap m_valid", m_valid[0], 1'b0);
    check("read gap grant", grant[0], 2'b00);
    tick();
    check("read idle m_valid", m_valid[0], 1'b0);

    // round robin from reset with both ports always requesting
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    c_valid[0][0] = 1'b1; c_valid[0][1] = 1'b1;
    tick();
    for (int t = 0; t < 4; t++) begin
      check($sformatf("rr grant %0d", t), grant[0], rr_exp[t]);
      check($sformatf("rr m_valid %0d", t), m_valid[0], 1'b1);
      m_ready[0] = 1'b1; m_rdata[0] = $urandom;
      tick();
      m_ready[0] = 1'b0;
      check($sformatf("rr gap %0d", t), m_valid[0], 1'b0);
      if (t == 3) begin
        c_valid[0][0] = 1'b0; c_valid[0][1] = 1'b0;
      end
      tick();
    end
    check("rr idle", m_valid[0], 1'b0);

    // fixed priority: c1 waits until c0 stops requesting
    c_valid[1][0] = 1'b1; c_valid[1][1] = 1'b1;
    tick();
    for (int t = 0; t < 3; t++) begin
      check($sformatf("fp grant c0 %0d", t), grant[1], 2'b01);
      m_ready[1] = 1'b1;
      tick();
      m_ready[1] = 1'b0;
      if (t == 2) c_valid[1][0] = 1'b0;
      tick();
    end
    check("fp grant c1", grant[1], 2'b10);
    m_ready[1] = 1'b1;
    tick();
    m_ready[1] = 1'b0; c_valid[1][1] = 1'b0;
    tick();
    check("fp idle grant", grant[1], 2'b00);

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog expiry: bridge never answers
    c_valid[0][1] = 1'b1; c_addr[0][1] = 32'h300;
    tick();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("wd grant cycle %0d", k), grant[0], 2'b10);
      check($sformatf("wd no err cycle %0d", k), terr[0], 1'b0);
      tick();
    end
    check("wd abort err", terr[0], 1'b1);
    check("wd abort c1 ready", c_ready[0][1], 1'b1);
    check("wd abort c1 rdata", c_rdata[0][1], 32'hDEAD_BEEF);
    check("wd abort m_valid", m_valid[0], 1'b0);
    c_valid[0][1] = 1'b0;
    tick();
    check("wd err pulse end", terr[0], 1'b0);
    check("wd after c1 ready", c_ready[0][1], 1'b0);

    // ready on the last permitted cycle completes normally
    c_valid[0][1] = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    m_ready[0] = 1'b1; m_rdata[0] = 32'hCAFE_F00D;
    #1;
    check("race c1 ready", c_ready[0][1], 1'b1);
    check("race c1 rdata", c_rdata[0][1], 32'hCAFE_F00D);
    check("race no err", terr[0], 1'b0);
    tick();
    m_ready[0] = 1'b0; c_valid[0][1] = 1'b0;
    check("race gap no err", terr[0], 1'b0);
    check("race gap m_valid", m_valid[0], 1'b0);
    tick();
`endif

    // reset in the middle of a write
    c_valid[0][0] = 1'b1; c_addr[0][0] = 32'h200; c_wdata[0][0] = 32'hA5A5_5A5A;
    c_wstrb[0][0] = 4'b0101; c_instr[0][0] = 1'b0;
    tick();
    check("wr m_wstrb", m_wstrb[0], 4'b0101);
    check("wr m_wdata", m_wdata[0], 32'hA5A5_5A5A);
    #2;
    resetn = 1'b0;
    #1;
    check("rst grant", grant[0], 2'b00);
    check("rst m_valid", m_valid[0], 1'b0);
    check("rst m_addr", m_addr[0], 32'd0);
    check("rst m_wdata", m_wdata[0], 32'd0);
    check("rst m_wstrb", m_wstrb[0], 4'd0);
    check("rst c0 ready", c_ready[0][0], 1'b0);
    check("rst timeout_err", terr[0], 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    check("post-rst grant", grant[0], 2'b01);
    check("post-rst m_wstrb", m_wstrb[0], 4'b0101);
    m_ready[0] = 1'b1;
    tick();
    m_ready[0] = 1'b0; c_valid[0][0] = 1'b0;
    tick();

    // randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) seen[i][p] = c_ready[i][p];
      tick();
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (c_valid[i][p]) begin
            if (seen[i][p]) begin
              c_valid[i][p] = ($urandom_range(2) == 0);
              if (c_valid[i][p]) new_payload(i, p);
            end
          end else if ($urandom_range(3) == 0) begin
            c_valid[i][p] = 1'b1;
            new_payload(i, p);
          end
        end
        m_ready[i] = ($urandom_range(2) == 0);
        m_rdata[i] = $urandom;
      end
    end

    // drain: let outstanding transactions finish, then stop requesting
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) seen[i][p] = c_ready[i][p];
      tick();
      for (int i = 0; i < 2; i++) begin
        m_ready[i] = 1'b1;
        for (int p = 0; p < 2; p++)
          if (seen[i][p]) c_valid[i][p] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) m_ready[i] = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
